// File: rtl/t_ff_pkg.sv
// t_ff_pkg
// Shared constants for the toggle flip-flop family: the default number of
// independent toggle bits and the default per-bit reset value.
// No ports; imported by the cell, the top and the bundling interface.
package t_ff_pkg;

   localparam int   T_FF_DEFAULT_WIDTH     = 1;
   localparam logic T_FF_DEFAULT_RESET_BIT = 1'b0;

endpackage : t_ff_pkg

// File: rtl/t_ff_if.sv
// t_ff_if
// Bundles the toggle-enable vector and the registered state of a t_ff so
// a producer of toggle requests can be wired to a bank of T flops as one
// object.
//   t : per-bit toggle enable (master drives, slave receives)
//   q : registered state      (slave drives, master observes)
interface t_ff_if
   import t_ff_pkg::*;
#(
   parameter int WIDTH = T_FF_DEFAULT_WIDTH
);

   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q;

   modport master (output t, input  q);
   modport slave  (input  t, output q);

endinterface : t_ff_if

// File: rtl/t_ff_cell.sv
// t_ff_cell
// Single-bit toggle flop with asynchronous active-high reset and a
// per-instance reset value.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces q to RESET_VAL at once
//   t     : toggle enable, sampled on the rising edge of clk
//   q     : registered state, driven straight from the flop
module t_ff_cell
   import t_ff_pkg::*;
#(
   parameter logic RESET_VAL = T_FF_DEFAULT_RESET_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q
);

   // Toggle only when t is a definite 1. An X or Z on t evaluates the
   // condition as false, so the flop holds instead of going unknown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RESET_VAL;
      end else if (t == 1'b1) begin
         q <= ~q;
      end else begin
         q <= q;
      end
   end

endmodule : t_ff_cell

// File: rtl/t_ff.sv
// t_ff
// Bank of WIDTH independent toggle flip-flops sharing one clock and one
// asynchronous active-high reset. The port order (clk, reset, t, q) is
// fixed so the block can be instantiated positionally.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; loads RESET_VAL into q
//   t     : per-bit toggle enable, WIDTH bits
//   q     : registered state, WIDTH bits
module t_ff
   import t_ff_pkg::*;
#(
   parameter int               WIDTH     = T_FF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{T_FF_DEFAULT_RESET_BIT}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q
);

   // One cell per bit; each picks its own bit of RESET_VAL.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_ff_cell #(
         .RESET_VAL (RESET_VAL[i])
      ) u_cell (
         .clk   (clk),
         .reset (reset),
         .t     (t[i]),
         .q     (q[i])
      );
   end

endmodule : t_ff

// File: tb/tb_t_ff.sv
// tb_t_ff
// Directed bench for t_ff: a default 1-bit instance and a 4-bit instance
// with a non-zero reset value, both driven through t_ff_if bundles.
// No ports.
module tb_t_ff;
   import t_ff_pkg::*;

   logic clk;
   logic reset;

   int checks;
   int errors;

   t_ff_if #(.WIDTH(1)) bus1 ();
   t_ff_if #(.WIDTH(4)) bus4 ();

   t_ff dut1 (
      .clk   (clk),
      .reset (reset),
      .t     (bus1.t),
      .q     (bus1.q)
   );

   t_ff #(
      .WIDTH     (4),
      .RESET_VAL (4'b1010)
   ) dut4 (
      .clk   (clk),
      .reset (reset),
      .t     (bus4.t),
      .q     (bus4.q)
   );

   // 10 ns clock that starts high; rising edges at 10, 20, 30, ...
   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   // Safety net so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s at %0t: observed %b expected %b",
                tag, $time, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic rst_val, input logic t1_val,
                                 input logic [3:0] t4_val);
      reset  = rst_val;
      bus1.t = t1_val;
      bus4.t = t4_val;
   endtask

   // Wait for the next rising edge and sample 1 ns later.
   task automatic step_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      bus4.t = 4'b0000;

      // Reset asserted at 5 ns with bus1.t left undriven (X).
      #5;
      reset = 1'b1;
      #1;
      check_output("reset_immediate_q1", {3'b000, bus1.q}, 4'b0000);
      check_output("reset_immediate_q4", bus4.q, 4'b1010);

      // Rising edges 10..50 are ignored while reset is high.
      for (int i = 0; i < 5; i++) begin
         step_edge();
         check_output("reset_hold_q1", {3'b000, bus1.q}, 4'b0000);
      end
      check_output("reset_hold_q4", bus4.q, 4'b1010);

      // Release at 65 ns; t stays X for bus1 until 125 ns.
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step_edge();
         check_output("x_t_hold_q1", {3'b000, bus1.q}, 4'b0000);
      end
      check_output("zero_t_hold_q4", bus4.q, 4'b1010);

      // 125 ns: toggle bus1 continuously; pulse bus4 with 0110 for one edge.
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 4'b0110);
      step_edge();
      check_output("toggle_130_q1", {3'b000, bus1.q}, 4'b0001);
      check_output("toggle_0110_q4", bus4.q, 4'b1100);
      @(negedge clk);
      bus4.t = 4'b0000;
      step_edge();
      check_output("toggle_140_q1", {3'b000, bus1.q}, 4'b0000);
      check_output("hold_after_pulse_q4", bus4.q, 4'b1100);
      step_edge();
      check_output("toggle_150_q1", {3'b000, bus1.q}, 4'b0001);

      // 155 ns: t = 0, q must hold at 1.
      @(negedge clk);
      bus1.t = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step_edge();
         check_output("hold_q1", {3'b000, bus1.q}, 4'b0001);
      end

      // 175 ns: t = 1 again; edge 180 brings q to 0.
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 4'b1111);
      step_edge();
      check_output("toggle_180_q1", {3'b000, bus1.q}, 4'b0000);
      check_output("toggle_1111_q4", bus4.q, 4'b0011);
      step_edge();
      check_output("toggle_190_q1", {3'b000, bus1.q}, 4'b0001);
      check_output("toggle_1111_again_q4", bus4.q, 4'b1100);

      // 193 ns: async reset mid-run, 3 ns after a rising edge.
      #2;
      reset = 1'b1;
      #1;
      check_output("async_mid_q1", {3'b000, bus1.q}, 4'b0000);
      check_output("async_mid_q4", bus4.q, 4'b1010);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b1, 4'b0000);
      step_edge();
      check_output("resume_after_release_q1", {3'b000, bus1.q}, 4'b0001);
      check_output("resume_after_release_q4", bus4.q, 4'b1010);
      step_edge();
      check_output("resume_second_q1", {3'b000, bus1.q}, 4'b0000);

      // Reset rising in the same time step as a clock edge: reset wins even
      // though t = 1 and q = 0 would otherwise toggle to 1.
      @(posedge clk);
      reset = 1'b1;
      #1;
      check_output("reset_wins_edge_q1", {3'b000, bus1.q}, 4'b0000);
      @(negedge clk);
      reset = 1'b0;
      step_edge();
      check_output("after_edge_reset_q1", {3'b000, bus1.q}, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_t_ff
